// File: rtl/rx_cmd_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_cmd_decode_if
// Purpose  : Byte-in / frame-out bundle between UART receiver and command parser.
// Revision : 1.0
// ============================================================================
interface rx_cmd_decode_if;
    logic [7:0]  rx_byte;
    logic        rx_byte_en;
    logic [63:0] rx_data;
    logic        rx_data_vld;
    logic        rx_busy;
    logic        frame_err;
    logic [7:0]  err_cnt;

    // master = byte source / frame consumer side, slave = the parser
    modport master (
        output rx_byte, rx_byte_en,
        input  rx_data, rx_data_vld, rx_busy, frame_err, err_cnt
    );
    modport slave (
        input  rx_byte, rx_byte_en,
        output rx_data, rx_data_vld, rx_busy, frame_err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rx_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module   : rx_cmd_decode
// Purpose  : Recovers C0 + 8 payload + CF command frames into a 64-bit word.
//            Optional inter-byte timeout enabled by macro RX_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module rx_cmd_decode #(
    parameter logic [7:0]  START_BYTE  = 8'hC0,
    parameter logic [7:0]  STOP_BYTE   = 8'hCF,
    parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    rx_cmd_decode_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RV_DATA = 2'd1,
        RV_STOP = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [63:0] sr_q,      sr_d;
    logic [63:0] data_q,    data_d;
    logic        vld_q,     vld_d;
    logic        busy_q,    busy_d;
    logic        err_q,     err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        timeout;
    logic        illegal;

`ifdef RX_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
    logic [31:0] idle_inc;

    // A strobe in the same cycle as expiry wins over the timeout
    always_comb begin
        idle_inc = idle_q + 32'd1;
        timeout  = (state_q != IDLE) && !bus.rx_byte_en && (idle_inc == TIMEOUT_CYC);
        idle_d   = (state_d == IDLE || bus.rx_byte_en) ? 32'd0 : idle_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= 32'd0;
        else        idle_q <= idle_d;
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
`endif

    assign illegal = (cnt_q > 4'd8) ||
                     !(state_q inside {IDLE, RV_DATA, RV_STOP});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        if (illegal) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (timeout) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            sr_d    = 64'd0;
            err_d   = 1'b1;
        end else if (bus.rx_byte_en) begin
            case (state_q)
                IDLE: begin
                    if (bus.rx_byte == START_BYTE) begin
                        state_d = RV_DATA;
                        cnt_d   = 4'd0;
                    end
                end
                RV_DATA: begin
                    if (cnt_q >= 4'd8) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        // delimiter values are ordinary payload here
                        sr_d  = {sr_q[55:0], bus.rx_byte};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) state_d = RV_STOP;
                    end
                end
                RV_STOP: begin
                    if (bus.rx_byte == STOP_BYTE) begin
                        data_d  = sr_q;
                        vld_d   = 1'b1;
                        state_d = IDLE;
                    end else if (bus.rx_byte == START_BYTE) begin
                        err_d   = 1'b1;
                        state_d = RV_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                    cnt_d = 4'd0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            sr_q      <= 64'd0;
            data_q    <= 64'd0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.rx_data_vld = vld_q;
    assign bus.rx_busy     = busy_q;
    assign bus.frame_err   = err_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_cmd_decode
// Purpose  : Directed frames with queued expected outputs and a separate monitor.
// Revision : 1.0
// ============================================================================
module tb_rx_cmd_decode;

    localparam int TMO = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_cmd_decode_if bus ();

    rx_cmd_decode #(
        .START_BYTE  (8'hC0),
        .STOP_BYTE   (8'hCF),
        .TIMEOUT_CYC (32'd50)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          kind;   // 1 = good frame, 2 = frame error
        logic [63:0] data;
        logic [7:0]  ecnt;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [7:0]  exp_ecnt  = 8'd0;
    logic [63:0] last_good = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [63:0] d, input int due);
        exp_t e;
        if (kind == 2) begin
            if (exp_ecnt != 8'hFF) exp_ecnt = exp_ecnt + 8'd1;
            e.data = last_good;
        end else begin
            last_good = d;
            e.data    = d;
        end
        e.kind = kind;
        e.ecnt = exp_ecnt;
        e.due  = due;
        exp_q.push_back(e);
    endtask

    // Output registered at the sampling edge, visible in that same cycle
    task automatic strobe(input logic [7:0] b, input int kind, input logic [63:0] d);
        @(negedge clk);
        bus.rx_byte    = b;
        bus.rx_byte_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_byte_en = 1'b0;
        if (kind != 0) push(kind, d, cyc);
    endtask

    task automatic payload(input logic [63:0] p);
        for (int i = 7; i >= 0; i--) strobe(p[i*8 +: 8], 0, 64'd0);
    endtask

    task automatic good_frame(input logic [63:0] p);
        strobe(8'hC0, 0, 64'd0);
        payload(p);
        strobe(8'hCF, 1, p);
    endtask

    task automatic bad_stop(input logic [63:0] p);
        strobe(8'hC0, 0, 64'd0);
        payload(p);
        strobe(8'h55, 2, 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.rx_data_vld || bus.frame_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {62'd0, bus.rx_data_vld, bus.frame_err}, 64'd0);
            end else begin
                m_e = exp_q.pop_front();
                check("vld_err_kind", {62'd0, bus.rx_data_vld, bus.frame_err},
                      (m_e.kind == 1) ? 64'd2 : 64'd1);
                check("rx_data", bus.rx_data, m_e.data);
                check("err_cnt", {56'd0, bus.err_cnt}, {56'd0, m_e.ecnt});
                check("latency_cycle", 64'(cyc), 64'(m_e.due));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_byte    = 8'h00;
        bus.rx_byte_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_data", bus.rx_data, 64'd0);
        check("rst_vld",     {63'd0, bus.rx_data_vld}, 64'd0);
        check("rst_busy",    {63'd0, bus.rx_busy}, 64'd0);
        check("rst_ferr",    {63'd0, bus.frame_err}, 64'd0);
        check("rst_err_cnt", {56'd0, bus.err_cnt}, 64'd0);
        rst_n = 1'b1;

        strobe(8'hC0, 0, 64'd0);
        check("busy_after_start", {63'd0, bus.rx_busy}, 64'd1);
        payload(64'h0123456789ABCDEF);
        check("busy_before_stop", {63'd0, bus.rx_busy}, 64'd1);
        strobe(8'hCF, 1, 64'h0123456789ABCDEF);
        check("busy_after_stop", {63'd0, bus.rx_busy}, 64'd0);

        bad_stop(64'h1122334455667788);
        repeat (2) @(negedge clk);
        check("bad_stop_err_cnt", {56'd0, bus.err_cnt}, 64'd1);
        check("bad_stop_data",    bus.rx_data, 64'h0123456789ABCDEF);
        check("bad_stop_idle",    {63'd0, bus.rx_busy}, 64'd0);

        strobe(8'hC0, 0, 64'd0);
        payload(64'h1111111111111111);
        strobe(8'hC0, 2, 64'd0);
        payload(64'h2222222222222222);
        strobe(8'hCF, 1, 64'h2222222222222222);

        good_frame(64'hC0CF000000000000);
        good_frame(64'h5A5AA5A5F00F0FF0);

        strobe(8'h7E, 0, 64'd0);
        strobe(8'hCF, 0, 64'd0);
        repeat (3) @(negedge clk);
        check("noise_idle", {63'd0, bus.rx_busy}, 64'd0);

        for (int n = 0; n < 260; n++) bad_stop(64'hDEAD0000BEEF0000 + 64'(n));
        repeat (2) @(negedge clk);
        check("err_cnt_saturated", {56'd0, bus.err_cnt}, 64'hFF);

        strobe(8'hC0, 0, 64'd0);
        for (int i = 0; i < 4; i++) strobe(8'h30 + 8'(i), 0, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #2;
        check("midrst_rx_data", bus.rx_data, 64'd0);
        check("midrst_busy",    {63'd0, bus.rx_busy}, 64'd0);
        check("midrst_err_cnt", {56'd0, bus.err_cnt}, 64'd0);
        check("midrst_vld_err", {62'd0, bus.rx_data_vld, bus.frame_err}, 64'd0);
        exp_ecnt  = 8'd0;
        last_good = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
        good_frame(64'hFEDCBA9876543210);

`ifdef RX_TIMEOUT_EN
        strobe(8'hC0, 0, 64'd0);
        strobe(8'hA1, 0, 64'd0);
        strobe(8'hA2, 0, 64'd0);
        strobe(8'hA3, 0, 64'd0);
        push(2, 64'd0, cyc + TMO);
        repeat (TMO + 5) @(negedge clk);
        check("timeout_idle", {63'd0, bus.rx_busy}, 64'd0);
        good_frame(64'h0F1E2D3C4B5A6978);
`endif

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_cmd_decode.md
Name: rx_cmd_decode

Overview:
- Receive-side command parser for the UART command link.
- Consumes bytes from the UART byte receiver and recovers 10-byte command frames: start byte 0xC0, 8 payload bytes (high byte first, big-endian), stop byte 0xCF.
- Presents each good frame as one 64-bit word with a single-cycle valid pulse; flags and counts malformed frames.
- Sits between the UART byte receiver and the command/register decode logic.

Parameters:
- START_BYTE, 8'hC0, frame start delimiter.
- STOP_BYTE, 8'hCF, frame stop delimiter.
- TIMEOUT_CYC, 32'd100000, inter-byte timeout in clk cycles (used only with RX_TIMEOUT_EN).

Ports:
- clk  in  1  system main clock
- rst_n  in  1  asynchronous active-low reset
- rx_byte  in  8  byte from UART receiver; valid only when rx_byte_en=1
- rx_byte_en  in  1  one-cycle strobe, one received byte per strobe
- rx_data  out  64  last good frame payload, first payload byte in [63:56]
- rx_data_vld  out  1  one-cycle pulse, rx_data newly updated
- rx_busy  out  1  high while a frame is in progress (state != IDLE)
- frame_err  out  1  one-cycle pulse on a malformed or aborted frame
- err_cnt  out  8  saturating count of frame_err pulses

Behaviour:
- Reset (async, rst_n=0) clears all outputs and internal state:
  - rx_data=0, rx_data_vld=0, rx_busy=0, frame_err=0, err_cnt=0.
  - State=IDLE, byte counter=0, shift register=0.
- All outputs are registered. Only rx_byte_en cycles advance the FSM; rx_byte is ignored when rx_byte_en=0.
- State IDLE:
  - Strobe with START_BYTE -> RV_DATA, counter=0.
  - Strobe with any other byte -> discarded, stay in IDLE, no error.
- State RV_DATA:
  - Each strobe shifts the byte in: sr <= {sr[55:0], rx_byte}; counter increments.
  - Bytes equal to 0xC0/0xCF are taken as payload (no escaping).
  - On the 8th payload strobe (counter 7->8) -> RV_STOP.
- State RV_STOP:
  - Strobe with STOP_BYTE -> rx_data<=sr, rx_data_vld=1 in the cycle after the strobe, -> IDLE.
  - Strobe with START_BYTE -> frame_err pulse, resync: -> RV_DATA, counter=0.
  - Strobe with any other byte -> frame_err pulse, -> IDLE.
- Latency: rx_data_vld and frame_err rise exactly 1 clk after the rx_byte_en cycle that caused them.
- rx_data holds its value until the next good frame; errored frames never modify rx_data.
- err_cnt increments on each frame_err and saturates at 8'hFF (no wrap).
- Counter is 4 bits and stays in 0..8; any illegal state or count value -> IDLE with counter cleared, no error pulse.
- Back-to-back frames: a START_BYTE arriving on the cycle immediately after the STOP strobe is accepted.
- rx_busy = (state != IDLE), registered together with state.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- Defined:
  - A 32-bit idle counter runs while state != IDLE and clears on every rx_byte_en.
  - When it reaches TIMEOUT_CYC: frame_err pulse, err_cnt increments, partial data discarded, -> IDLE.
  - If a strobe arrives in the same cycle the timeout is reached, the strobe takes priority and the timeout is ignored.
- Not defined: no counter is built; a partial frame waits indefinitely; TIMEOUT_CYC is unused.

Test Plan:
- Good frame: strobes C0,01,23,45,67,89,AB,CD,EF,CF -> one rx_data_vld pulse 1 clk after the CF strobe, rx_data=64'h0123456789ABCDEF, frame_err never asserted, rx_busy high from C0 until after CF.
- Bad stop: C0, 8 payload bytes, then 0x55 -> frame_err pulse, err_cnt=1, no rx_data_vld, rx_data unchanged, state IDLE.
- Resync: C0, 8 bytes of 11, then C0, then 8 bytes of 22, then CF -> one frame_err, then rx_data=64'h2222222222222222 with rx_data_vld.
- Delimiter-valued payload: C0,C0,CF,00,00,00,00,00,00,CF -> rx_data=64'hC0CF000000000000. Noise bytes 0x7E,0xCF in IDLE -> no output activity.
- Saturation and reset: 260 bad-stop frames -> err_cnt=8'hFF. Assert rst_n low mid-frame (after 4 payload bytes) -> all outputs 0; a following good frame decodes correctly.
- RX_TIMEOUT_EN with TIMEOUT_CYC=50: C0 plus 3 bytes, then silence -> frame_err exactly 50 clks after the last strobe, rx_busy low; the next good frame decodes normally.
